prefetch_request_queue: RTL and testbench
=========================================

// Module: prefetch_request_queue
// PURPOSE
//  Downstream stage of the 3D neighbour prefetcher. Each single-cycle address pulse from the prefetcher is buffered here.
//  Addresses that are already queued or were issued recently are dropped. The rest go to the memory request port over a valid/ready handshake.
//  The prefetcher has no stall input, so this block never back-pressures it; overflow is dropped and counted.
// PARAMETERS
//  ADDR_W  32  address width
//  DEPTH   8   FIFO entries; power of 2, >=2
//  HIST    4   recently-issued addresses kept for duplicate filtering, >=1
//  CNT_W   16  width of saturating statistics counters
// PORTS
//  clock       in   1                  rising-edge clock
//  reset       in   1                  synchronous, active-high
//  address_i   in   ADDR_W             candidate prefetch address (prefetcher address_o)
//  valid       in   1                  address_i qualifier (prefetcher ready); one address per pulse
//  flush       in   1                  discard all queued and history state
//  req_addr    out  ADDR_W             head-of-queue address to memory
//  req_valid   out  1                  request valid
//  req_ready   in   1                  memory accepts request
//  count       out  $clog2(DEPTH)+1    occupancy
//  full        out  1                  count==DEPTH
//  empty       out  1                  count==0
//  dup_count   out  CNT_W              saturating count of duplicate drops
//  drop_count  out  CNT_W              saturating count of overflow drops
// BEHAVIOUR
//  - Single clock domain (clock). reset is synchronous and active-high.
//  - Reset values: count=0, empty=1, full=0, req_valid=0, req_addr=0, dup_count=0, drop_count=0; all history entries invalid.
//  - Handshake:
//    - deq = req_valid & req_ready.
//    - req_valid = !empty.
//    - req_addr = head entry, or 0 when empty.
//    - While req_valid & !req_ready, req_addr stays stable.
//  - Duplicate check, applied when valid=1:
//    - hit if address_i equals any occupied FIFO entry (head included, even if dequeued this cycle),
//    - or equals any valid history entry.
//    - Hit -> input dropped, dup_count+1. Duplicate takes priority over the overflow check.
//  - Overflow:
//    - a non-duplicate input is enqueued if count<DEPTH, or if count==DEPTH and deq in the same cycle;
//    - otherwise it is dropped and drop_count+1.
//  - Latency: an address enqueued at edge N is visible on req_addr/req_valid in cycle N+1 (earliest issue).
//  - Order: strict FIFO; wptr/rptr wrap modulo DEPTH.
//  - count: +1 on enq only, -1 on deq only, unchanged on both in the same cycle.
//  - History: on deq, the head address shifts into history slot 0 and the oldest entry is discarded. The history is a shift register of HIST entries, each with a valid bit.
//  - flush:
//    - next edge: count=0, pointers=0, all history invalid;
//    - a valid in the same cycle is ignored and not counted;
//    - req_ready is ignored that cycle.
//  - Counters saturate at 2**CNT_W-1. They are cleared only by reset, not by flush.
//  - Reset in the middle of traffic: queued entries are lost and req_valid deasserts the next cycle; no partial request is issued.
//  - Priority: reset > flush > enqueue/dequeue.
// STRUCTURE
//  - pf_pkg: typedef logic [ADDR_W-1:0] addr_t; default constants for DEPTH, HIST, CNT_W; function sat_inc(cnt) for the saturating counters.
//  - Sub-module prefetch_recent_filter: HIST-deep history shift register plus a parallel compare, with match output.
//  - Top level: FIFO storage and pointers, occupancy logic, and the FIFO-entry compare.
// TESTING
//  - Reset: hold reset 2 cycles -> empty=1, req_valid=0, req_addr=0, count=0, both counters 0.
//  - Order: req_ready=0; pulse 12,14,10,16,4,22 (neighbours of 13 in a 3x3x3 grid) -> count=6, req_addr=12.
//    Then req_ready=1 -> issued 12,14,10,16,4,22 on 6 consecutive cycles, then empty=1.
//  - Duplicates:
//    - push 12 while 12 is queued -> dup_count=1, count unchanged;
//    - after 12 issues, push 12 -> dup (history hit);
//    - after 4 further issues, push 12 -> accepted.
//  - Overflow: DEPTH=8, req_ready=0; push 9 distinct addresses -> count=8, full=1, drop_count=1.
//    Then a 10th push in the same cycle as a handshake -> accepted, count stays 8.
//  - Flush: flush=1 together with valid (addr 5) -> next cycle count=0; 5 not queued and not counted.
//    A recently issued address pushed after the flush is accepted (history cleared).
//  - Saturation and reset: CNT_W=2; 5 overflow drops -> drop_count=3.
//    Reset while req_valid=1 -> req_valid=0 the next cycle and counters 0.

Source files
------------

// File: rtl/prefetch_request_queue_pkg.sv
// Shared types, default sizes and helpers for the prefetch request queue.
package pf_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DEPTH_DEF  = 8;
    localparam int HIST_DEF   = 4;
    localparam int CNT_W_DEF  = 16;

    // Widest statistics counter the helper below can handle.
    localparam int CNT_MAX_W  = 32;

    typedef logic [ADDR_W_DEF-1:0] addr_t;

    // Increment a counter that is 'width' bits wide, holding at all-ones.
    function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] cnt,
                                                     input int unsigned           width);
        logic [CNT_MAX_W:0] limit;
        limit = ((CNT_MAX_W+1)'(1) << width) - (CNT_MAX_W+1)'(1);
        if ({1'b0, cnt} >= limit) begin
            return cnt;
        end
        return cnt + CNT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/prefetch_request_queue_if.sv
// Memory request channel: head-of-queue address with a valid/ready handshake.
interface prefetch_request_queue_if
    import pf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);

    logic [ADDR_W-1:0] req_addr;
    logic              req_valid;
    logic              req_ready;

    modport master (
        output req_addr,
        output req_valid,
        input  req_ready
    );

    modport slave (
        input  req_addr,
        input  req_valid,
        output req_ready
    );

endinterface

// File: rtl/prefetch_request_queue_recent.sv
// History of recently issued addresses, used to drop prefetches that were
// sent to memory only a few requests ago.
module prefetch_recent_filter
    import pf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int HIST   = HIST_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [ADDR_W-1:0] check_addr,
    output logic              match
);

    logic [ADDR_W-1:0] hist_addr [HIST];
    logic [HIST-1:0]   hist_valid;

    // Shift the issued address into slot 0; the oldest entry falls off the end.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist_valid <= '0;
            for (int i = 0; i < HIST; i++) begin
                hist_addr[i] <= '0;
            end
        end else if (flush) begin
            hist_valid <= '0;
        end else if (push) begin
            hist_addr[0]  <= push_addr;
            hist_valid[0] <= 1'b1;
            for (int i = 1; i < HIST; i++) begin
                hist_addr[i]  <= hist_addr[i-1];
                hist_valid[i] <= hist_valid[i-1];
            end
        end
    end

    // Parallel compare of the candidate against every valid history slot.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < HIST; i++) begin
            if (hist_valid[i] && (hist_addr[i] == check_addr)) begin
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prefetch_request_queue.sv
// Buffers prefetch addresses, drops duplicates and overflow, and presents
// the oldest address to memory. The upstream prefetcher cannot stall, so
// every input is either enqueued or dropped in the cycle it arrives.
module prefetch_request_queue
    import pf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int HIST   = HIST_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        address_i,
    input  logic                     valid,
    input  logic                     flush,
    prefetch_request_queue_if.master req,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         dup_count,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  slot_off;
    logic [ADDR_W-1:0] head_addr;

    logic fifo_hit;
    logic hist_hit;
    logic live_in;
    logic dup;
    logic deq;
    logic enq;
    logic ovf;

    assign empty     = (count == '0);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign head_addr = fifo_mem[rptr];

    assign req.req_valid = !empty;
    assign req.req_addr  = empty ? '0 : head_addr;

    // A flush cycle ignores both the input pulse and the memory handshake.
    assign live_in = valid && !flush;
    assign deq     = req.req_valid && req.req_ready && !flush;
    assign dup     = live_in && (fifo_hit || hist_hit);
    assign enq     = live_in && !dup && (!full || deq);
    assign ovf     = live_in && !dup && full && !deq;

    // Compare the candidate against every occupied slot, head included.
    always_comb begin
        fifo_hit = 1'b0;
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - rptr;
            if (({1'b0, slot_off} < count) && (fifo_mem[i] == address_i)) begin
                fifo_hit = 1'b1;
            end
        end
    end

    prefetch_recent_filter #(
        .ADDR_W (ADDR_W),
        .HIST   (HIST)
    ) u_recent (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .push       (deq),
        .push_addr  (head_addr),
        .check_addr (address_i),
        .match      (hist_hit)
    );

    // FIFO storage, wrapping pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                fifo_mem[wptr] <= address_i;
                wptr           <= wptr + PTR_W'(1);
            end
            if (deq) begin
                rptr <= rptr + PTR_W'(1);
            end
            if (enq && !deq) begin
                count <= count + (PTR_W+1)'(1);
            end else if (deq && !enq) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

    // Saturating drop statistics; survive flush, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            dup_count  <= '0;
            drop_count <= '0;
        end else begin
            if (dup) begin
                dup_count <= CNT_W'(sat_inc(CNT_MAX_W'(dup_count), unsigned'(CNT_W)));
            end
            if (ovf) begin
                drop_count <= CNT_W'(sat_inc(CNT_MAX_W'(drop_count), unsigned'(CNT_W)));
            end
        end
    end

endmodule

// File: tb/tb_prefetch_request_queue.sv
// Directed bench for prefetch_request_queue. Two instances share all stimulus:
// one with 16-bit counters and one with 2-bit counters to exercise saturation.
module tb_prefetch_request_queue;
    import pf_pkg::*;

    logic        clock;
    logic        reset;
    addr_t       address_i;
    logic        valid;
    logic        flush;
    logic        req_ready;

    logic [3:0]  count, count_s;
    logic        full, full_s;
    logic        empty, empty_s;
    logic [15:0] dup_count, drop_count;
    logic [1:0]  dup_count_s, drop_count_s;

    int n_compared;
    int n_mismatched;

    prefetch_request_queue_if #(.ADDR_W(32)) bus ();
    prefetch_request_queue_if #(.ADDR_W(32)) bus_s ();

    assign bus.req_ready   = req_ready;
    assign bus_s.req_ready = req_ready;

    prefetch_request_queue #(
        .ADDR_W(32), .DEPTH(8), .HIST(4), .CNT_W(16)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .address_i  (address_i),
        .valid      (valid),
        .flush      (flush),
        .req        (bus.master),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .dup_count  (dup_count),
        .drop_count (drop_count)
    );

    prefetch_request_queue #(
        .ADDR_W(32), .DEPTH(8), .HIST(4), .CNT_W(2)
    ) u_sat (
        .clock      (clock),
        .reset      (reset),
        .address_i  (address_i),
        .valid      (valid),
        .flush      (flush),
        .req        (bus_s.master),
        .count      (count_s),
        .full       (full_s),
        .empty      (empty_s),
        .dup_count  (dup_count_s),
        .drop_count (drop_count_s)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Count one comparison and report it if it disagrees.
    task automatic check_output(input string tag, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one single-cycle address pulse, optionally with flush.
    task automatic apply_stimulus(input addr_t addr, input logic fl);
        address_i = addr;
        valid     = 1'b1;
        flush     = fl;
        tick();
        valid     = 1'b0;
        flush     = 1'b0;
    endtask

    addr_t order_list [6];

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b1;
        address_i    = '0;
        valid        = 1'b0;
        flush        = 1'b0;
        req_ready    = 1'b0;
        order_list   = '{32'd12, 32'd14, 32'd10, 32'd16, 32'd4, 32'd22};

        // Reset held for two cycles.
        tick();
        tick();
        check_output("rst_empty",     64'(empty),        64'd1);
        check_output("rst_req_valid", 64'(bus.req_valid), 64'd0);
        check_output("rst_req_addr",  64'(bus.req_addr),  64'd0);
        check_output("rst_count",     64'(count),         64'd0);
        check_output("rst_full",      64'(full),          64'd0);
        check_output("rst_dup",       64'(dup_count),     64'd0);
        check_output("rst_drop",      64'(drop_count),    64'd0);
        reset = 1'b0;
        tick();

        // Fill with the neighbour addresses while memory is stalled.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(order_list[i], 1'b0);
        end
        check_output("fill_count",     64'(count),         64'd6);
        check_output("fill_req_addr",  64'(bus.req_addr),  64'd12);
        check_output("fill_req_valid", 64'(bus.req_valid), 64'd1);

        // 12 is still queued at the head.
        apply_stimulus(32'd12, 1'b0);
        check_output("dupq_dup",   64'(dup_count), 64'd1);
        check_output("dupq_count", 64'(count),     64'd6);

        // Drain in order; re-push 12 just after it issued (history hit).
        req_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_output($sformatf("issue%0d", i), 64'(bus.req_addr), 64'(order_list[i]));
            if (i == 1) begin
                apply_stimulus(32'd12, 1'b0);
                check_output("duph_dup", 64'(dup_count), 64'd2);
            end else begin
                tick();
            end
        end
        check_output("drain_empty",     64'(empty),         64'd1);
        check_output("drain_req_valid", 64'(bus.req_valid), 64'd0);
        check_output("drain_req_addr",  64'(bus.req_addr),  64'd0);

        // 12 has aged out of the history, so it is accepted again.
        apply_stimulus(32'd12, 1'b0);
        check_output("reacc_count", 64'(count),        64'd1);
        check_output("reacc_addr",  64'(bus.req_addr), 64'd12);
        check_output("reacc_dup",   64'(dup_count),    64'd2);
        tick();
        check_output("reacc_empty", 64'(empty), 64'd1);

        // Overflow: nine distinct pushes into eight slots.
        req_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(addr_t'(100 + i), 1'b0);
        end
        check_output("ovf_count",    64'(count),        64'd8);
        check_output("ovf_full",     64'(full),         64'd1);
        check_output("ovf_drop",     64'(drop_count),   64'd1);
        check_output("ovf_drop_sat", 64'(drop_count_s), 64'd1);
        check_output("ovf_head",     64'(bus.req_addr), 64'd100);

        // Push while full but with a handshake in the same cycle.
        req_ready = 1'b1;
        apply_stimulus(32'd109, 1'b0);
        req_ready = 1'b0;
        check_output("ovfhs_count", 64'(count),        64'd8);
        check_output("ovfhs_drop",  64'(drop_count),   64'd1);
        check_output("ovfhs_head",  64'(bus.req_addr), 64'd101);

        // Four more overflow drops; the 2-bit counter stops at 3.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(addr_t'(110 + i), 1'b0);
        end
        check_output("sat_drop",     64'(drop_count),   64'd5);
        check_output("sat_drop_sat", 64'(drop_count_s), 64'd3);

        // Duplicates take priority over overflow while full.
        apply_stimulus(32'd101, 1'b0);
        apply_stimulus(32'd102, 1'b0);
        check_output("sat_dup",      64'(dup_count),    64'd4);
        check_output("sat_dup_sat",  64'(dup_count_s),  64'd3);
        check_output("dupfull_drop", 64'(drop_count),   64'd5);

        // Flush with a simultaneous pulse and ready; pulse must be ignored.
        req_ready = 1'b1;
        apply_stimulus(32'd5, 1'b1);
        req_ready = 1'b0;
        check_output("flush_count", 64'(count),      64'd0);
        check_output("flush_empty", 64'(empty),      64'd1);
        check_output("flush_dup",   64'(dup_count),  64'd4);
        check_output("flush_drop",  64'(drop_count), 64'd5);

        // 100 was issued just before the flush; history is now clear.
        apply_stimulus(32'd100, 1'b0);
        check_output("posthist_count", 64'(count),        64'd1);
        check_output("posthist_addr",  64'(bus.req_addr), 64'd100);
        check_output("posthist_dup",   64'(dup_count),    64'd4);

        // Reset while a request is pending.
        check_output("prerst_valid", 64'(bus.req_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("midrst_valid",    64'(bus.req_valid),   64'd0);
        check_output("midrst_count",    64'(count),           64'd0);
        check_output("midrst_drop",     64'(drop_count),      64'd0);
        check_output("midrst_dup",      64'(dup_count),       64'd0);
        check_output("midrst_drop_sat", 64'(drop_count_s),    64'd0);
        check_output("midrst_valid_s",  64'(bus_s.req_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
